// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared constants and types for the instruction-fetch controller.
//   - Memory map: PC_RESET, IM_BASE, IM_WORDS, IM_LAST, EXC_VECTOR, NOP
//   - npc_sel_e: which source feeds the next PC (SEQ, REDIR, EXC, ERET)
//   - ifid_t:    contents of the IF/ID pipeline register
//   - fetch_addr_err(): misaligned or outside instruction memory
package fetch_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam int unsigned IM_WORDS   = 4096;
  // Last legal byte address of the instruction memory (0x6FFF).
  localparam logic [31:0] IM_LAST    = IM_BASE + 32'(4 * IM_WORDS) - 32'd1;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEQ   = 2'd0,
    REDIR = 2'd1,
    EXC   = 2'd2,
    ERET  = 2'd3
  } npc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        adel;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP, pc: 32'h0, valid: 1'b0, adel: 1'b0};

  function automatic logic fetch_addr_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
  endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// fetch_npc_sel
//   Combinational next-PC selection. Applies the request priority
//   exception > ERET > stall > redirect > sequential.
// Ports:
//   pc_i          current fetch address
//   stall_i       hold request from the hazard unit
//   redirect_i    branch taken / jump in decode
//   redirect_pc_i branch/jump target
//   exc_req_i     exception/interrupt accepted
//   eret_i        ERET executing
//   epc_i         ERET return address
//   npc_o         PC to load at the next edge (equals pc_i while holding)
//   sel_o         source of npc_o (SEQ also reported while holding)
//   hold_o        PC, IF/ID and the fetch counter must keep their values
module fetch_npc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic [31:0] npc_o,
  output npc_sel_e    sel_o,
  output logic        hold_o
);

  always_comb begin
    npc_o  = pc_i + 32'd4;  // wraps modulo 2^32
    sel_o  = SEQ;
    hold_o = 1'b0;
    if (exc_req_i) begin
      npc_o = EXC_VECTOR;
      sel_o = EXC;
    end else if (eret_i) begin
      npc_o = epc_i;
      sel_o = ERET;
    end else if (stall_i) begin
      // A stalled redirect is dropped; the decoder re-asserts it once the
      // stall clears.
      npc_o  = pc_i;
      hold_o = 1'b1;
    end else if (redirect_i) begin
      // Target is loaded as-is; a bad target is flagged when it is fetched.
      npc_o = redirect_pc_i;
      sel_o = REDIR;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction-fetch controller: owns the PC and the IF/ID register and
//   counts fetches committed into IF/ID.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   stall_i        freeze PC, IF/ID and the fetch counter
//   redirect_i     branch/jump; redirect_pc_i is the target (delay slot kept)
//   exc_req_i      jump to EXC_VECTOR and flush IF/ID
//   eret_i, epc_i  jump to epc_i and flush IF/ID
//   pc_o           fetch address to the instruction memory
//   instr_i        memory read data for pc_o (combinational)
//   instr_d_o, pc_d_o, valid_d_o, adel_d_o   IF/ID register
//   fetch_cnt_o    committed-fetch counter
// Handshake: none; stall_i is a level hold applied at the clock edge, and
//   exception/ERET override it. After a flush IF/ID holds one bubble.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_d_o,
  output logic        valid_d_o,
  output logic        adel_d_o,
  output logic [31:0] fetch_cnt_o
);

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] npc;
  npc_sel_e    sel;
  logic        hold;
  logic        adel_f;
  logic [31:0] instr_f;

  fetch_npc_sel u_npc_sel (
    .pc_i          (pc_q),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .exc_req_i     (exc_req_i),
    .eret_i        (eret_i),
    .epc_i         (epc_i),
    .npc_o         (npc),
    .sel_o         (sel),
    .hold_o        (hold)
  );

  // A bad fetch address never lets memory data into the pipe.
  assign adel_f  = fetch_addr_err(pc_q);
  assign instr_f = adel_f ? NOP : instr_i;

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    if (!hold) begin
      pc_d = npc;
      unique case (sel)
        EXC, ERET: ifid_d = IFID_BUBBLE;
        default: begin
          // Sequential and redirect both commit the current fetch; for a
          // redirect this is the delay slot.
          ifid_d = '{instr: instr_f, pc: pc_q, valid: 1'b1, adel: adel_f};
          cnt_d  = cnt_q + 32'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= PC_RESET;
      ifid_q <= IFID_BUBBLE;
      cnt_q  <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign instr_d_o   = ifid_q.instr;
  assign pc_d_o      = ifid_q.pc;
  assign valid_d_o   = ifid_q.valid;
  assign adel_d_o    = ifid_q.adel;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch controller that sequences the 4096-word instruction memory (base 0x0000_3000). It owns the PC register and the IF/ID pipeline register. It selects the next PC among sequential, redirect (branch/jump with delay slot), exception entry and ERET return. It also honours pipeline stalls and flags fetch address errors.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_WORDS, 4096, instruction-memory depth in words; legal range is IM_BASE to IM_BASE+4*IM_WORDS-1 (0x3000–0x6FFF)
EXC_VECTOR, 32'h0000_4180, exception handler entry address

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall_i  in  1  hazard unit hold request: freeze PC and IF/ID
redirect_i  in  1  D-stage branch taken / jump
redirect_pc_i  in  32  branch/jump target
exc_req_i  in  1  exception/interrupt accepted this cycle
eret_i  in  1  ERET executing
epc_i  in  32  return address for ERET
pc_o  out  32  current fetch address to the instruction memory
instr_i  in  32  instruction-memory read data for pc_o (combinational)
instr_d_o  out  32  IF/ID instruction
pc_d_o  out  32  IF/ID PC
valid_d_o  out  1  IF/ID holds a real fetch (0 = bubble)
adel_d_o  out  1  IF/ID fetch address error (misaligned or out of range)
fetch_cnt_o  out  32  number of fetches committed into IF/ID

Behaviour:
- Reset (async, immediate): pc_o=PC_RESET; instr_d_o=0; pc_d_o=0; valid_d_o=0; adel_d_o=0; fetch_cnt_o=0.
- adel_f (combinational) = pc_o[1:0]!=0, or pc_o<IM_BASE, or pc_o>IM_BASE+4*IM_WORDS-1.
- When adel_f=1, the fetched word is forced to 0 (nop) before entering IF/ID.
- Per-edge priority, highest first:
  1. exc_req_i: pc<=EXC_VECTOR; IF/ID<=bubble (instr 0, pc_d 0, valid 0, adel 0). Overrides stall_i.
  2. eret_i: pc<=epc_i; IF/ID<=bubble. Overrides stall_i.
  3. stall_i: pc and IF/ID hold; fetch_cnt_o holds; redirect_i is ignored (the decoder re-asserts it).
  4. redirect_i: pc<=redirect_pc_i; IF/ID<={fetched word, pc_o, valid 1, adel_f}. The word fetched this cycle is the delay slot and is kept.
  5. Otherwise: pc<=pc_o+4 (wraps modulo 2^32); IF/ID<={fetched word, pc_o, 1, adel_f}.
- fetch_cnt_o increments by 1 on each edge of cases 4 or 5, including adel fetches. It wraps from 0xFFFF_FFFF to 0.
- Latency: pc_o to IF/ID is 1 cycle. A redirect, exception or ERET takes effect on pc_o at the next edge.
- State: implicit RUN/FLUSH. After case 1 or 2 there is exactly one bubble cycle (valid_d_o=0), then normal fetch resumes from the new pc.
- Simultaneous exc_req_i and eret_i: exception wins.
- redirect_pc_i or epc_i may be misaligned or out of range. It is loaded unchanged and reported via adel_d_o one cycle later.
- Reset asserted mid-stall or mid-flush returns all outputs to reset values immediately.

Decomposition:
- Shared package holds PC_RESET, IM_BASE, IM_WORDS, EXC_VECTOR, NOP=32'h0, and a 2-bit next-PC select encoding: SEQ, REDIR, EXC, ERET.
- One natural sub-module: fetch_npc_sel. It is combinational, computing the next-PC and the select from the request inputs. The registers stay in fetch_ctrl.

Test Plan:
- Reset with instr_i echoing a word per pc, run 3 cycles → pc_o 0x3000, 0x3004, 0x3008; pc_d_o 0x3000 then 0x3004; valid_d_o=1 from cycle 1; fetch_cnt_o=2.
- At pc_o=0x3008, pulse redirect_i with target 0x3100 → IF/ID gets pc 0x3008 (delay slot); next pc_o=0x3100.
- Hold stall_i 2 cycles at pc_o=0x300C with redirect_i=1 → pc_o, pc_d_o and fetch_cnt_o unchanged; redirect ignored.
- exc_req_i together with stall_i and eret_i at pc_o=0x3010 → pc_o=0x4180, valid_d_o=0 for 1 cycle. Then eret_i with epc_i=0x3014 → pc_o=0x3014, one bubble.
- redirect to 0x3002 and to 0x7000 → adel_d_o=1 and instr_d_o=0 for that fetch; fetch_cnt_o still increments.
- Assert reset during a stall with pc_o=0x3020 → pc_o=0x3000 and valid_d_o=0 asynchronously, before the next clock edge.
